// File: rtl/sort4_sched.sv
// Four-lane unsigned sorter: one shared compare-swap unit walks a fixed 5-step network.
// Latency: result valid 6 cycles after the input handshake cycle; initiation interval 7.
// Backpressure: result held in DONE until out_ready; in_ready low until the cycle after.
//
// Optional feature macro: SORT4_SCHED_SWAPCNT_EN (adds swap_cnt output).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i, in_valid     unsorted word (4 lanes of W bits) and its valid
//   in_ready        high only in IDLE
//   o, out_valid    sorted word (lane 3 largest) and its valid, high only in DONE
//   out_ready       consumer accepts o
//   busy            high while sorting
//   swap_cnt        (optional) number of exchanges made for the current word
module sort4_sched #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*W-1:0] i,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*W-1:0] o,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef SORT4_SCHED_SWAPCNT_EN
  output logic [2:0]     swap_cnt,
`endif
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [2:0]     step_q;
  logic [4*W-1:0] work_q;
  logic [4*W-1:0] work_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;

  logic [1:0]     hi_idx;
  logic [1:0]     lo_idx;
  logic [W-1:0]   lane_h;
  logic [W-1:0]   lane_l;
  logic           do_swap;

  // Step-to-pair mapping of the 4-input sorting network. Steps 5..7 never
  // occur; they alias the last pair so the decode stays fully specified.
  always_comb begin
    hi_idx = 2'd2;
    lo_idx = 2'd1;
    case (step_q)
      3'd0:    begin hi_idx = 2'd3; lo_idx = 2'd1; end
      3'd1:    begin hi_idx = 2'd2; lo_idx = 2'd0; end
      3'd2:    begin hi_idx = 2'd3; lo_idx = 2'd2; end
      3'd3:    begin hi_idx = 2'd1; lo_idx = 2'd0; end
      default: begin hi_idx = 2'd2; lo_idx = 2'd1; end
    endcase
  end

  // The single shared compare-swap unit. Strict compare: equal lanes stay put.
  always_comb begin
    lane_h  = work_q[int'(hi_idx)*W +: W];
    lane_l  = work_q[int'(lo_idx)*W +: W];
    do_swap = (lane_l > lane_h);
    work_d  = work_q;
    if (do_swap) begin
      work_d[int'(hi_idx)*W +: W] = lane_l;
      work_d[int'(lo_idx)*W +: W] = lane_h;
    end
  end

`ifdef SORT4_SCHED_SWAPCNT_EN
  logic [2:0] swap_cnt_q;
  assign swap_cnt = swap_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 3'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SORT4_SCHED_SWAPCNT_EN
      swap_cnt_q  <= 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= i;
            step_q     <= 3'd0;
            state_q    <= SORT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SORT4_SCHED_SWAPCNT_EN
            swap_cnt_q <= 3'd0;
`endif
          end
        end
        SORT: begin
          work_q <= work_d;
`ifdef SORT4_SCHED_SWAPCNT_EN
          swap_cnt_q <= swap_cnt_q + {2'b00, do_swap};
`endif
          if (step_q == 3'd4) begin
            // Counter parks at 0 so it never holds an unreachable value.
            step_q      <= 3'd0;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          step_q      <= 3'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign o         = work_q;

endmodule

// File: tb/tb_sort4_sched.sv
// Directed bench for sort4_sched (W=4): vector table plus hold, reset and streaming sequences.
module tb_sort4_sched;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef SORT4_SCHED_SWAPCNT_EN
  logic [2:0]  swap_cnt;
`endif

  sort4_sched #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SORT4_SCHED_SWAPCNT_EN
    .swap_cnt  (swap_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_swaps(input string name, input int exp);
`ifdef SORT4_SCHED_SWAPCNT_EN
    chk(name, {29'd0, swap_cnt}, exp);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid; returns ticks taken including the accept tick.
  task automatic wait_result(output int n);
    n = 1;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    int          swaps;
  } vec_t;

  vec_t vecs[9];

  task automatic run_word(input logic [15:0] din, input logic [15:0] dout, input int swaps,
                          input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " in_ready before"}, {31'd0, in_ready}, 1);
    i         = din;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    i        = ~din;  // must not disturb the captured word
    chk({tag, " busy"}, {31'd0, busy}, 1);
    chk({tag, " in_ready sort"}, {31'd0, in_ready}, 0);
    wait_result(n);
    chk({tag, " latency"}, n, 6);
    chk({tag, " o"}, {16'd0, o}, {16'd0, dout});
    chk_swaps({tag, " swap_cnt"}, swaps);
    chk({tag, " in_ready done"}, {31'd0, in_ready}, 0);
    chk({tag, " busy done"}, {31'd0, busy}, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " in_ready after"}, {31'd0, in_ready}, 1);
    chk({tag, " out_valid after"}, {31'd0, out_valid}, 0);
  endtask

  logic [15:0] bw_in [4];
  logic [15:0] bw_out[4];

  initial begin
    int n;
    int acc;
    int res;
    int cyc;
    int last;
    bit took;

    vecs[0] = '{16'h1234, 16'h4321, 4};
    vecs[1] = '{16'hFA50, 16'hFA50, 0};
    vecs[2] = '{16'h7777, 16'h7777, 0};
    vecs[3] = '{16'h0F3C, 16'hFC30, 4};
    vecs[4] = '{16'h4321, 16'h4321, 0};
    vecs[5] = '{16'h000F, 16'hF000, 2};
    vecs[6] = '{16'h8142, 16'h8421, 2};
    vecs[7] = '{16'h1F1F, 16'hFF11, 3};
    vecs[8] = '{16'h0000, 16'h0000, 0};

    rst       = 1'b1;
    i         = 16'hBEEF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 1);
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset o", {16'd0, o}, 0);
    chk_swaps("reset swap_cnt", 0);

    for (int k = 0; k < 9; k++) begin
      run_word(vecs[k].din, vecs[k].dout, vecs[k].swaps, $sformatf("vec%0d", k));
    end

    // Result held under backpressure while the producer keeps pushing.
    i        = 16'h8142;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(n);
    chk("hold latency", n, 6);
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      i         = 16'h1111 * 16'(k + 3);
      out_ready = 1'b0;
      tick();
      chk($sformatf("hold o c%0d", k), {16'd0, o}, 32'h8421);
      chk($sformatf("hold out_valid c%0d", k), {31'd0, out_valid}, 1);
      chk($sformatf("hold in_ready c%0d", k), {31'd0, in_ready}, 0);
      chk_swaps($sformatf("hold swap_cnt c%0d", k), 2);
    end
    i         = 16'h0F3C;
    out_ready = 1'b1;
    chk("hold in_ready on out hs", {31'd0, in_ready}, 0);
    tick();
    out_ready = 1'b0;
    chk("hold in_ready next", {31'd0, in_ready}, 1);
    chk("hold out_valid next", {31'd0, out_valid}, 0);
    tick();
    in_valid = 1'b0;
    chk("hold new word busy", {31'd0, busy}, 1);
    wait_result(n);
    chk("hold new word latency", n, 6);
    chk("hold new word o", {16'd0, o}, 32'hFC30);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while step s2 is current.
    i        = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("midreset busy before", {31'd0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset in_ready", {31'd0, in_ready}, 1);
    chk("midreset out_valid", {31'd0, out_valid}, 0);
    chk("midreset busy", {31'd0, busy}, 0);
    chk("midreset o", {16'd0, o}, 0);
    chk_swaps("midreset swap_cnt", 0);
    run_word(16'h0F3C, 16'hFC30, 4, "postreset");

    // Streaming: both valid and ready held high.
    bw_in[0] = 16'h1234; bw_out[0] = 16'h4321;
    bw_in[1] = 16'h0F3C; bw_out[1] = 16'hFC30;
    bw_in[2] = 16'h8142; bw_out[2] = 16'h8421;
    bw_in[3] = 16'h1F1F; bw_out[3] = 16'hFF11;
    i         = bw_in[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc  = 0;
    res  = 0;
    cyc  = 0;
    last = 0;
    while (res < 4 && cyc < 200) begin
      took = 1'b0;
      if (in_valid && in_ready) begin
        if (acc > 0) chk($sformatf("b2b spacing %0d", acc), cyc - last, 7);
        last = cyc;
        acc++;
        took = 1'b1;
      end
      if (out_valid) begin
        chk($sformatf("b2b o %0d", res), {16'd0, o}, {16'd0, bw_out[res]});
        chk($sformatf("b2b in_ready excl %0d", res), {31'd0, in_ready}, 0);
        res++;
      end
      tick();
      cyc++;
      if (took) begin
        if (acc < 4) i = bw_in[acc];
        else         in_valid = 1'b0;
      end
    end
    chk("b2b results", res, 4);
    chk("b2b accepts", acc, 4);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort4_sched.md
SORT4_SCHED -- requirements
Module: sort4_sched

Interface
REQ-001 Parameter W, default 4: lane width in bits; data ports are 4*W bits wide as four lanes, lane k = bits [k*W +: W], k = 0..3.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i  input  4*W  unsorted word, sampled on input handshake.
REQ-005 in_valid  input  1  producer has a word on i.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 o  output  4*W  sorted word: lane 3 largest, lane 0 smallest.
REQ-008 out_valid  output  1  o holds a completed result.
REQ-009 out_ready  input  1  consumer accepts o.
REQ-010 busy  output  1  high in SORT state.

Function
REQ-011 Datapath SHALL contain exactly one shared unsigned compare-swap unit over a 4*W-bit working register; one pair per cycle.
REQ-012 Compare-swap(h,l): if lane l > lane h (strict unsigned), exchange the lanes; otherwise hold (equal values never swap).
REQ-013 Step sequence, fixed: s0 (3,1), s1 (2,0), s2 (3,2), s3 (1,0), s4 (2,1).
REQ-014 FSM states: IDLE, SORT, DONE; 3-bit step counter.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1, load i into the working register, clear step counter, go to SORT.
REQ-016 SORT: in_ready=0, busy=1; each edge applies the current step and increments the counter; the edge applying s4 goes to DONE.
REQ-017 DONE: out_valid=1, o = working register, stable while out_ready=0; on out_ready=1, go to IDLE.
REQ-018 Latency: input-handshake edge at cycle T gives out_valid=1 from cycle T+6; minimum initiation interval 7 cycles.
REQ-019 in_valid SHALL be ignored outside IDLE; changes on i after acceptance SHALL NOT affect the result.
REQ-020 in_ready and out_valid SHALL never be high together; a new word is accepted only on or after the cycle following an output handshake.
REQ-021 o SHALL be driven from the working register at all times; it is meaningful only while out_valid=1.
REQ-022 Step counter SHALL NOT advance outside SORT; values 5..7 are unreachable.

Reset
REQ-023 rst=1 at any clock edge, including mid-SORT or in DONE, SHALL force IDLE, step counter=0, working register=0, and swap_cnt=0 when present; any in-flight word is discarded.
REQ-024 In the cycle after reset: in_ready=1, out_valid=0, busy=0, o=0.

Configuration
REQ-025 Macro SORT4_SCHED_SWAPCNT_EN defined: add output swap_cnt, 3 bits; cleared on input handshake; incremented on each SORT edge that exchanges lanes; held stable in DONE with o.
REQ-026 Macro SORT4_SCHED_SWAPCNT_EN undefined: swap_cnt port and counter absent; all other behaviour identical.

Verification
REQ-027 W=4, i=16'h1234, in_valid pulse, out_ready=1 -> out_valid at T+6, o=16'h4321, swap_cnt=4.
REQ-028 i=16'hFA50 (already sorted) -> o=16'hFA50, swap_cnt=0; i=16'h7777 -> o=16'h7777, swap_cnt=0.
REQ-029 Result ready, out_ready=0 for 3 cycles with in_valid=1 and i changing -> o, out_valid=1, in_ready=0 all held; new word accepted only from the cycle after out_ready=1.
REQ-030 rst=1 during step s2 of i=16'h1234 -> next cycle in_ready=1, out_valid=0, busy=0, o=0; a following i=16'h0F3C then yields o=16'hFC30.
REQ-031 Back-to-back: in_valid held high, out_ready held high, 4 words -> acceptances exactly 7 cycles apart, each o correctly sorted.
